mult_div_unit: RTL and testbench

- Execute-stage consumer of the 4-bit ALU control code for the HI/LO class of instructions.
- Iterative signed multiply (code 4'b0101, MULT) and signed divide (code 4'b1011, DIV), writing the HI/LO architectural registers.
- Also services MTHI/MTLO writes and exposes HI/LO continuously for MFHI/MFLO.
- The pipeline hazard unit stalls on `busy`.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/mdu_div_step.sv | 21 ++
 rtl/mult_div_unit.sv | 133 +++++++++++++
 tb/tb_mult_div_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS execute-stage definitions: operand width, ALU control codes and the
// multiply/divide unit state encoding.
package mips_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 6;

  localparam logic [3:0] ALU_CTRL_MULT = 4'b0101;
  localparam logic [3:0] ALU_CTRL_DIV  = 4'b1011;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FINISH
  } mdu_state_t;

  // Two's-complement magnitude; -2^(XLEN-1) maps to its unsigned bit pattern.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v);
    return v[XLEN-1] ? -v : v;
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in the next dividend bit and subtract the
// divisor when it fits. A zero divisor always "fits", so the remainder collects the dividend.
module mdu_div_step
  import mips_pkg::*;
(
  input  logic [XLEN-1:0] rem,
  input  logic            dividend_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic            q_bit
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  assign shifted  = {rem, dividend_bit};
  assign diff     = shifted - {1'b0, divisor};
  assign q_bit    = (shifted >= {1'b0, divisor});
  assign rem_next = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed MULT/DIV unit owning the HI/LO registers, with MTHI/MTLO writes.
// Define MDU_FAST_MULT_EN to replace the shift-add multiply with a single-cycle multiply.
module mult_div_unit
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  mdu_state_t state, state_next;

  logic [CNT_W-1:0]  count;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   op_b;
  logic              rs_neg, rt_neg, is_div, div_zero;
  logic              accept;
  logic [XLEN-1:0]   rem_next;
  logic              q_bit;
  logic [2*XLEN-1:0] mul_res;
  logic [XLEN-1:0]   quo_res, rem_res;

  // DIV reuses the product register: upper half is the remainder, lower half
  // shifts the dividend out while the quotient shifts in.
  mdu_div_step u_div_step (
    .rem          (prod[2*XLEN-1:XLEN]),
    .dividend_bit (prod[XLEN-1]),
    .divisor      (op_b),
    .rem_next     (rem_next),
    .q_bit        (q_bit)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start && (alu_control == ALU_CTRL_MULT || alu_control == ALU_CTRL_DIV)) begin
          accept     = 1'b1;
          state_next = (alu_control == ALU_CTRL_MULT) ? MUL : DIV;
        end
      end
`ifdef MDU_FAST_MULT_EN
      MUL:     state_next = FINISH;
`else
      MUL:     if (count == CNT_W'(XLEN-1)) state_next = FINISH;
`endif
      DIV:     if (count == CNT_W'(XLEN-1)) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_comb begin
    mul_res = (rs_neg ^ rt_neg) ? -prod : prod;
    quo_res = (rs_neg ^ rt_neg) ? -prod[XLEN-1:0] : prod[XLEN-1:0];
    if (div_zero) quo_res = '1;
    rem_res = rs_neg ? -prod[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN];
  end

`ifndef MDU_FAST_MULT_EN
  logic [XLEN:0] mul_sum;
  assign mul_sum = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, op_b} : '0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      count    <= '0;
      prod     <= '0;
      op_b     <= '0;
      rs_neg   <= 1'b0;
      rt_neg   <= 1'b0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (accept) begin
            prod     <= {{XLEN{1'b0}}, abs_val(rs_val)};
            op_b     <= abs_val(rt_val);
            rs_neg   <= rs_val[XLEN-1];
            rt_neg   <= rt_val[XLEN-1];
            is_div   <= (alu_control == ALU_CTRL_DIV);
            div_zero <= (rt_val == '0);
            count    <= '0;
          end
        end
        MUL: begin
`ifdef MDU_FAST_MULT_EN
          prod <= {{XLEN{1'b0}}, prod[XLEN-1:0]} * {{XLEN{1'b0}}, op_b};
`else
          prod <= {mul_sum, prod[XLEN-1:1]};
`endif
          count <= count + CNT_W'(1);
        end
        DIV: begin
          prod  <= {rem_next, prod[XLEN-2:0], q_bit};
          count <= count + CNT_W'(1);
        end
        FINISH: begin
          if (is_div) {hi, lo} <= {rem_res, quo_res};
          else        {hi, lo} <= mul_res;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus randomized
// MULT/DIV traffic compared against a plain signed-arithmetic reference.
module tb_mult_div_unit;
  import mips_pkg::*;

`ifdef MDU_FAST_MULT_EN
  localparam int MUL_LAT = 3;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;

  logic        clk = 1'b0;
  logic        reset, start, hi_we, lo_we;
  logic [3:0]  alu_control;
  logic [31:0] rs_val, rt_val, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  mult_div_unit dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .alu_control (alu_control),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Architectural result {hi,lo} from signed arithmetic, with the defined corner cases.
  function automatic logic [63:0] refModel(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
    longint pa, pb;
    int     sa, sb;
    if (code == ALU_CTRL_MULT) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
      return 64'(pa * pb);
    end
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa = a;
    sb = b;
    return {32'(sa % sb), 32'(sa / sb)};
  endfunction

  // Issue one operation, optionally disturbing inputs while busy, and check timing and result.
  task automatic applyStimulus(input string tag, input logic [3:0] code,
                               input logic [31:0] a, input logic [31:0] b, input bit disturb);
    logic [63:0] exp;
    int          cycles;
    int          lat;
    bit          busy_ok;
    exp     = refModel(code, a, b);
    lat     = (code == ALU_CTRL_MULT) ? MUL_LAT : DIV_LAT;
    busy_ok = 1'b1;
    @(negedge clk);
    start       = 1'b1;
    alu_control = code;
    rs_val      = a;
    rt_val      = b;
    @(posedge clk);
    #1;
    start  = 1'b0;
    cycles = 1;
    while (cycles < 60 && !done) begin
      if (!busy) busy_ok = 1'b0;
      if (disturb) begin
        rs_val      = $urandom;
        rt_val      = $urandom;
        start       = $urandom_range(0, 1);
        alu_control = ALU_CTRL_MULT;
        hi_we       = 1'b1;
        lo_we       = $urandom_range(0, 1);
        wdata       = 32'hDEAD;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    checkOutput({tag, "_latency"}, 64'(cycles), 64'(lat));
    checkOutput({tag, "_busy_held"}, 64'(busy_ok), 64'd1);
    checkOutput({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    checkOutput({tag, "_hilo"}, {hi, lo}, exp);
    @(posedge clk);
    #1;
    checkOutput({tag, "_done_pulse"}, 64'(done), 64'd0);
    checkOutput({tag, "_hilo_hold"}, {hi, lo}, exp);
  endtask

  task automatic moveTo(input bit to_hi, input logic [31:0] d);
    @(negedge clk);
    hi_we = to_hi;
    lo_we = ~to_hi;
    wdata = d;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    lo_we = 1'b0;
  endtask

  initial begin
    logic [31:0] specials[5];
    logic [31:0] ra, rb;
    logic [3:0]  rc;
    bit          seen_done;
    specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    alu_control = 4'h0; rs_val = '0; rt_val = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_hilo", {hi, lo}, 64'd0);

    applyStimulus("mult_7_m3", ALU_CTRL_MULT, 32'd7, 32'hFFFF_FFFD, 1'b0);
    applyStimulus("div_m17_5", ALU_CTRL_DIV, 32'hFFFF_FFEF, 32'd5, 1'b0);
    applyStimulus("div_by_zero", ALU_CTRL_DIV, 32'd100, 32'd0, 1'b0);
    applyStimulus("div_overflow", ALU_CTRL_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    applyStimulus("mult_min_min", ALU_CTRL_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);
    applyStimulus("mult_12_12", ALU_CTRL_MULT, 32'd12, 32'd12, 1'b0);
    applyStimulus("div_busy_disturb", ALU_CTRL_DIV, 32'd1000, 32'hFFFF_FFF9, 1'b1);
    applyStimulus("mult_busy_disturb", ALU_CTRL_MULT, 32'h1234_5678, 32'hFEDC_BA98, 1'b1);

    moveTo(1'b0, 32'h1234);
    checkOutput("mtlo_idle", 64'(lo), 64'h1234);
    moveTo(1'b1, 32'h55AA);
    checkOutput("mthi_idle", 64'(hi), 64'h55AA);

    @(negedge clk);
    start = 1'b1;
    alu_control = 4'b0010;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("bad_code_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("bad_code_busy_later", 64'(busy), 64'd0);

    @(negedge clk);
    start = 1'b1;
    alu_control = ALU_CTRL_DIV;
    rs_val = 32'd77;
    rt_val = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_hilo", {hi, lo}, 64'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen_done = 1'b1;
      @(posedge clk);
      #1;
    end
    checkOutput("abort_no_done", 64'(seen_done), 64'd0);

    for (int n = 0; n < 24; n++) begin
      rc = ($urandom_range(0, 1) == 0) ? ALU_CTRL_MULT : ALU_CTRL_DIV;
      case ($urandom_range(0, 3))
        0:       begin ra = $urandom; rb = $urandom; end
        1:       begin ra = 32'($urandom_range(0, 40)) - 32'd20; rb = 32'($urandom_range(0, 40)) - 32'd20; end
        2:       begin ra = specials[$urandom_range(0, 4)]; rb = specials[$urandom_range(0, 4)]; end
        default: begin ra = $urandom; rb = 32'($urandom_range(0, 255)) - 32'd128; end
      endcase
      applyStimulus("random", rc, ra, rb, n[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
